// File: rtl/mem_responder.sv
// mem_responder: bus target for the CPU memory interface.
//
// Decodes each request into byte RAM (0 .. 2^RAM_AW-1), a four-register I/O window at IO_BASE,
// or unmapped space. Every request completes with a one-cycle ack, WAIT+1 cycles after the req
// cycle. The I/O window fronts a TX byte FIFO that a valid/ready consumer drains.
//
// I/O registers (offset from IO_BASE):
//   +0 TXDATA  write pushes into the FIFO (dropped and flagged as overflow when full); reads 0x00
//   +1 STATUS  read {overflow, 5'b0, full, empty}; the read clears overflow
//   +2 COUNT   read FIFO occupancy
//   +3 TIMER   free-running 8-bit timer when IO_TIMER_EN is defined, else reads 0x00
//
// Build option: define IO_TIMER_EN to include the timer at IO_BASE+3.
//
// Ports:
//   clk           system clock, rising edge
//   reset         asynchronous active-high reset
//   addr/req/we/wdata   request; sampled only in the req cycle while idle
//   rdata/ack     completion; rdata is valid only while ack=1
//   io_out_data   FIFO head byte (0x00 when empty)
//   io_out_valid  FIFO non-empty
//   io_out_ready  consumer takes the head this cycle
module mem_responder #(
    parameter int unsigned RAM_AW     = 11,
    parameter logic [15:0] IO_BASE    = 16'hD000,
    parameter int unsigned WAIT       = 0,
    parameter int unsigned FIFO_DEPTH = 8
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] addr,
    input  logic        req,
    input  logic        we,
    input  logic [7:0]  wdata,
    output logic [7:0]  rdata,
    output logic        ack,
    output logic [7:0]  io_out_data,
    output logic        io_out_valid,
    input  logic        io_out_ready
);
    localparam int unsigned PtrW    = $clog2(FIFO_DEPTH);
    localparam int unsigned CntW    = PtrW + 1;
    localparam int unsigned RamSize = 1 << RAM_AW;
    localparam logic [1:0]  WaitM1  = (WAIT > 0) ? 2'(WAIT - 1) : 2'd0;

    // Elaboration-time parameter checks.
    if (RAM_AW < 1 || RAM_AW > 15) begin : g_bad_ram_aw
        $error("mem_responder: RAM_AW must be 1..15");
    end
    if ({16'd0, IO_BASE} < RamSize || {16'd0, IO_BASE} + 32'd3 > 32'hFFFF) begin : g_overlap
        $error("mem_responder: I/O window overlaps RAM or exceeds the address space");
    end
    if (WAIT > 3) begin : g_bad_wait
        $error("mem_responder: WAIT must be 0..3");
    end
    if (FIFO_DEPTH < 2 || FIFO_DEPTH > 16 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0)
    begin : g_bad_depth
        $error("mem_responder: FIFO_DEPTH must be a power of two in 2..16");
    end

    typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

    state_e          state_q, state_d;
    logic [1:0]      cnt_q, cnt_d;
    logic [15:0]     addr_q, addr_d;
    logic            we_q, we_d;
    logic [7:0]      wdata_q, wdata_d;

    logic            overflow_q, overflow_d;
    logic [PtrW-1:0] wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CntW-1:0] count_q, count_d;
    logic [7:0]      fifo_q [FIFO_DEPTH];

    logic [7:0]      ram_q [RamSize];

    logic [15:0]     io_off;
    logic            ram_hit, io_hit;
    logic            ram_we, push, status_rd, timer_wr;
    logic            empty, full, pop, push_ok;
    logic [7:0]      timer_val;

    // Decode uses the captured address; the I/O test wraps mod 2^16, so only the true window hits.
    assign io_off  = addr_q - IO_BASE;
    assign ram_hit = ({16'd0, addr_q} < RamSize);
    assign io_hit  = !ram_hit && (io_off[15:2] == 14'd0);

    assign empty        = (count_q == '0);
    assign full         = (count_q == CntW'(FIFO_DEPTH));
    assign pop          = !empty && io_out_ready;
    // A pop in the same cycle frees the slot a push into a full FIFO needs.
    assign push_ok      = push && (!full || pop);
    assign io_out_valid = !empty;
    assign io_out_data  = empty ? 8'h00 : fifo_q[rd_ptr_q];

    // Request FSM and access decode.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        addr_d    = addr_q;
        we_d      = we_q;
        wdata_d   = wdata_q;
        ack       = 1'b0;
        rdata     = 8'h00;
        ram_we    = 1'b0;
        push      = 1'b0;
        status_rd = 1'b0;
        timer_wr  = 1'b0;
        case (state_q)
            StIdle: begin
                if (req) begin
                    addr_d  = addr;
                    we_d    = we;
                    wdata_d = wdata;
                    if (WAIT > 0) begin
                        state_d = StWait;
                        cnt_d   = WaitM1;
                    end else begin
                        state_d = StResp;
                    end
                end
            end
            StWait: begin
                if (cnt_q == 2'd0) begin
                    state_d = StResp;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            StResp: begin
                ack     = 1'b1;
                state_d = StIdle;
                if (ram_hit) begin
                    if (we_q) begin
                        ram_we = 1'b1;
                    end else begin
                        rdata = ram_q[addr_q[RAM_AW-1:0]];
                    end
                end else if (io_hit) begin
                    unique case (io_off[1:0])
                        2'd0: push = we_q;
                        2'd1: begin
                            if (!we_q) begin
                                rdata     = {overflow_q, 5'b0, full, empty};
                                status_rd = 1'b1;
                            end
                        end
                        2'd2: rdata = we_q ? 8'h00 : 8'(count_q);
                        2'd3: begin
                            if (we_q) begin
                                timer_wr = 1'b1;
                            end else begin
                                rdata = timer_val;
                            end
                        end
                    endcase
                end else if (!we_q) begin
                    rdata = 8'hFF;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // FIFO pointers, occupancy and overflow flag.
    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        overflow_d = overflow_q;
        if (push_ok) begin
            wr_ptr_d = wr_ptr_q + PtrW'(1);
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PtrW'(1);
        end
        case ({push_ok, pop})
            2'b10:   count_d = count_q + CntW'(1);
            2'b01:   count_d = count_q - CntW'(1);
            default: count_d = count_q;
        endcase
        // Push and STATUS read are never in the same RESP cycle, so set/clear cannot collide.
        if (push && full && !pop) begin
            overflow_d = 1'b1;
        end else if (status_rd) begin
            overflow_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= StIdle;
            cnt_q      <= 2'd0;
            addr_q     <= 16'h0000;
            we_q       <= 1'b0;
            wdata_q    <= 8'h00;
            overflow_q <= 1'b0;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            overflow_q <= overflow_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
        end
    end

    // Storage arrays are not reset; the FIFO head is masked while empty.
    always_ff @(posedge clk) begin
        if (push_ok) begin
            fifo_q[wr_ptr_q] <= wdata_q;
        end
        if (ram_we) begin
            ram_q[addr_q[RAM_AW-1:0]] <= wdata_q;
        end
    end

`ifdef IO_TIMER_EN
    logic [7:0] timer_q, timer_d;

    // A write makes the RESP cycle hold wdata, so the next cycle already reads wdata+1.
    always_comb begin
        timer_d = timer_wr ? wdata_q + 8'd1 : timer_q + 8'd1;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            timer_q <= 8'h00;
        end else begin
            timer_q <= timer_d;
        end
    end

    assign timer_val = timer_q;
`else
    logic unused_timer_wr;
    assign unused_timer_wr = timer_wr;
    assign timer_val       = 8'h00;
`endif

endmodule

// File: tb/tb_mem_responder.sv
`timescale 1ns/1ps
module tb_mem_responder;
    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset_a, reset_c;
    logic [15:0] addr;
    logic        we;
    logic [7:0]  wdata;
    logic        io_out_ready;
    logic [2:0]  req;

    logic [7:0] rdata0, rdata2, rdata3;
    logic       ack0, ack2, ack3;
    logic [7:0] io_data0, io_data2, io_data3;
    logic       io_valid0, io_valid2, io_valid3;

    // Instance index 0: WAIT=0, 1: WAIT=2, 2: WAIT=3 (own reset for the mid-access reset test).
    mem_responder #(.WAIT(0)) u_dut0 (
        .clk(clk), .reset(reset_a), .addr(addr), .req(req[0]), .we(we), .wdata(wdata),
        .rdata(rdata0), .ack(ack0), .io_out_data(io_data0), .io_out_valid(io_valid0),
        .io_out_ready(io_out_ready)
    );
    mem_responder #(.WAIT(2)) u_dut2 (
        .clk(clk), .reset(reset_a), .addr(addr), .req(req[1]), .we(we), .wdata(wdata),
        .rdata(rdata2), .ack(ack2), .io_out_data(io_data2), .io_out_valid(io_valid2),
        .io_out_ready(io_out_ready)
    );
    mem_responder #(.WAIT(3)) u_dut3 (
        .clk(clk), .reset(reset_c), .addr(addr), .req(req[2]), .we(we), .wdata(wdata),
        .rdata(rdata3), .ack(ack3), .io_out_data(io_data3), .io_out_valid(io_valid3),
        .io_out_ready(io_out_ready)
    );

    typedef struct {
        int         dut;
        int         cyc;
        bit         chk;
        logic [7:0] data;
        string      name;
    } exp_t;

    exp_t       sb[$];
    logic [7:0] out_q[$];
    int         lat[3] = '{1, 3, 4};
    int         checks = 0;
    int         errors = 0;
    int         cyc = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic mon_ack(input int d, input logic [7:0] rd);
        exp_t e;
        checks++;
        if (sb.size() == 0) begin
            errors++;
            $display("FAIL ack_unexpected: got ack dut=%0d cyc=%0d rdata=%02h, required no ack",
                     d, cyc, rd);
        end else begin
            e = sb.pop_front();
            if (e.dut != d || e.cyc != cyc || (e.chk && rd !== e.data)) begin
                errors++;
                $display("FAIL %s: got dut=%0d cyc=%0d rdata=%02h, required dut=%0d cyc=%0d rdata=%02h",
                         e.name, d, cyc, rd, e.dut, e.cyc, e.data);
            end
        end
    endtask

    // Monitor: pops the scoreboard on every ack and the byte queue on every dut0 FIFO pop.
    always @(negedge clk) begin
        logic [7:0] eb;
        if (ack0 === 1'b1) mon_ack(0, rdata0);
        if (ack2 === 1'b1) mon_ack(1, rdata2);
        if (ack3 === 1'b1) mon_ack(2, rdata3);
        if (io_valid0 === 1'b1 && io_out_ready === 1'b1) begin
            checks++;
            if (out_q.size() == 0) begin
                errors++;
                $display("FAIL pop_unexpected: got byte %02h, required no pop", io_data0);
            end else begin
                eb = out_q.pop_front();
                if (io_data0 !== eb) begin
                    errors++;
                    $display("FAIL pop_data: got %02h, required %02h", io_data0, eb);
                end
            end
        end
    end

    task automatic chk(input string name, input logic [7:0] got, input logic [7:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %02h, required %02h", name, got, exp);
        end
    endtask

    // Called at posedge+1ns; issues one request and waits (bounded) for its ack.
    task automatic do_req(input int d, input bit w, input logic [15:0] a, input logic [7:0] wd,
                          input bit c, input logic [7:0] exp, input string name,
                          input bit pulse_rdy);
        exp_t e;
        int   n;
        addr   = a;
        we     = w;
        wdata  = wd;
        req[d] = 1'b1;
        e.dut  = d;
        e.cyc  = cyc + lat[d];
        e.chk  = c;
        e.data = exp;
        e.name = name;
        sb.push_back(e);
        @(posedge clk); #1;
        req[d] = 1'b0;
        if (pulse_rdy) io_out_ready = 1'b1;
        n = 0;
        while (sb.size() != 0 && n < 12) begin
            @(posedge clk); #1;
            n++;
        end
        if (pulse_rdy) io_out_ready = 1'b0;
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got no ack, required ack at cycle %0d", name, e.cyc);
            sb.delete();
        end
    endtask

    task automatic wr(input int d, input logic [15:0] a, input logic [7:0] wd, input string name);
        do_req(d, 1'b1, a, wd, 1'b0, 8'h00, name, 1'b0);
    endtask

    task automatic rd(input int d, input logic [15:0] a, input logic [7:0] exp, input string name);
        do_req(d, 1'b0, a, 8'h00, 1'b1, exp, name, 1'b0);
    endtask

    task automatic drain(input string name);
        int n;
        io_out_ready = 1'b1;
        n = 0;
        while (out_q.size() != 0 && n < 40) begin
            @(posedge clk); #1;
            n++;
        end
        io_out_ready = 1'b0;
        if (out_q.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d bytes missing, required 0", name, out_q.size());
            out_q.delete();
        end
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: got no finish, required finish before 1ms");
        $fatal(1, "watchdog");
    end

    initial begin
        reset_a = 1'b1;
        reset_c = 1'b1;
        req = 3'b000;
        addr = 16'h0000;
        we = 1'b0;
        wdata = 8'h00;
        io_out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_ack", {7'd0, ack0}, 8'h00);
        chk("rst_rdata", rdata0, 8'h00);
        chk("rst_valid", {7'd0, io_valid0}, 8'h00);
        chk("rst_io_data", io_data0, 8'h00);
        reset_a = 1'b0;
        reset_c = 1'b0;
        @(posedge clk); #1;

        rd(0, 16'hD001, 8'h01, "status_after_reset");

        // RAM and unmapped space, WAIT=0.
        wr(0, 16'h0042, 8'h5A, "wr_ram_42");
        rd(0, 16'h0042, 8'h5A, "rd_ram_42");
        wr(0, 16'h0000, 8'h66, "wr_ram_0");
        wr(0, 16'h07FF, 8'h3C, "wr_ram_top");
        rd(0, 16'h07FF, 8'h3C, "rd_ram_top");
        rd(0, 16'h0800, 8'hFF, "rd_above_ram");
        rd(0, 16'h9000, 8'hFF, "rd_unmapped");
        wr(0, 16'h9000, 8'h11, "wr_unmapped");
        wr(0, 16'h9042, 8'h22, "wr_unmapped2");
        rd(0, 16'h0000, 8'h66, "ram0_unchanged");
        rd(0, 16'h0042, 8'h5A, "ram42_unchanged");
        rd(0, 16'hCFFF, 8'hFF, "rd_below_io");
        rd(0, 16'hD004, 8'hFF, "rd_above_io");

        // Overflow with the consumer stalled.
        for (int i = 1; i <= 9; i++) wr(0, 16'hD000, 8'(i), "push_ovf");
        rd(0, 16'hD002, 8'h08, "count_full");
        rd(0, 16'hD001, 8'h82, "status_ovf");
        rd(0, 16'hD001, 8'h02, "status_ovf_cleared");
        rd(0, 16'hD000, 8'h00, "txdata_read");
        for (int i = 1; i <= 8; i++) out_q.push_back(8'(i));
        drain("drain_ovf");
        rd(0, 16'hD001, 8'h01, "status_drained");
        rd(0, 16'hD002, 8'h00, "count_drained");

        // Push into a full FIFO while the head is popped in the same cycle.
        for (int i = 0; i < 8; i++) wr(0, 16'hD000, 8'(8'h21 + i), "push_fill");
        out_q.push_back(8'h21);
        do_req(0, 1'b1, 16'hD000, 8'hAA, 1'b0, 8'h00, "push_full_pop", 1'b1);
        rd(0, 16'hD002, 8'h08, "count_push_pop");
        rd(0, 16'hD001, 8'h02, "status_push_pop");
        for (int i = 0; i < 7; i++) out_q.push_back(8'(8'h22 + i));
        out_q.push_back(8'hAA);
        drain("drain_push_pop");

`ifdef IO_TIMER_EN
        wr(0, 16'hD003, 8'h10, "timer_wr");
        @(posedge clk); #1;
        rd(0, 16'hD003, 8'h13, "timer_rd");
`else
        wr(0, 16'hD003, 8'h10, "timer_wr");
        rd(0, 16'hD003, 8'h00, "timer_absent_rd");
`endif

        // WAIT=2 latency: the scoreboard expects ack exactly 3 cycles after req.
        wr(1, 16'h0042, 8'h77, "w2_wr");
        rd(1, 16'h0042, 8'h77, "w2_rd");

        // WAIT=3: reset during the wait states abandons the access.
        for (int i = 1; i <= 3; i++) wr(2, 16'hD000, 8'(i), "w3_push");
        chk("w3_valid_before", {7'd0, io_valid3}, 8'h01);
        addr = 16'h0042;
        we = 1'b0;
        req[2] = 1'b1;
        @(posedge clk); #1;
        req[2] = 1'b0;
        @(posedge clk); #1;
        reset_c = 1'b1;
        #1;
        chk("w3_valid_in_reset", {7'd0, io_valid3}, 8'h00);
        @(posedge clk); #1;
        reset_c = 1'b0;
        repeat (6) @(posedge clk);
        #1;
        chk("w3_valid_after", {7'd0, io_valid3}, 8'h00);
        chk("w3_data_after", io_data3, 8'h00);
        rd(2, 16'hD001, 8'h01, "w3_status_after");

        chk("sb_drained", 8'(sb.size()), 8'h00);
        chk("out_drained", 8'(out_q.size()), 8'h00);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
